// File: rtl/boreal_ledger_pkg.sv
// Shared types and sizes for the boreal_ledger feeder: word/entry geometry,
// the entry type carried through the FIFO and the drain FSM state encoding.
package boreal_ledger_pkg;

    localparam int WORD_W          = 32;
    localparam int ENTRY_W         = 256;
    localparam int WORDS_PER_ENTRY = ENTRY_W / WORD_W;
    localparam int WIDX_W          = $clog2(WORDS_PER_ENTRY);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [1:0] {
        DRN_IDLE   = 2'd0,
        DRN_COMMIT = 2'd1,
        DRN_GAP    = 2'd2
    } drain_state_t;

endpackage

// File: rtl/boreal_entry_fifo.sv
// Synchronous FIFO of completed ledger entries. A push while full is accepted
// when a pop happens in the same cycle, so a full FIFO never blocks a
// simultaneous push/pop pair. Storage is not reset; only pointers and count are.
module boreal_entry_fifo
    import boreal_ledger_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    // Entry storage: written on every accepted push, no reset on data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/boreal_ledger_feeder.sv
// boreal_ledger_feeder: packs 32-bit stream words into 256-bit ledger entries,
// queues closed entries in boreal_entry_fifo and drains them as one-cycle
// wr_en/wr_data commits separated by at least WR_GAP idle cycles.
// Optional build macro BOREAL_FEEDER_CNT_EN adds entry_cnt / pad_cnt outputs.
module boreal_ledger_feeder
    import boreal_ledger_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WR_GAP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   wr_en,
    output logic [ENTRY_W-1:0]     wr_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy
`ifdef BOREAL_FEEDER_CNT_EN
    ,
    output logic [31:0]            entry_cnt,
    output logic [31:0]            pad_cnt
`endif
);

    localparam int                GAP_W    = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(WR_GAP);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_ENTRY - 1);

    // Builds the closed entry: words below idx come from the partial buffer,
    // the closing word goes at idx, everything above is zero padding. This
    // keeps stale words from an earlier entry out of short entries without
    // having to clear the partial buffer.
    function automatic entry_t close_entry(entry_t part, word_t w, logic [WIDX_W-1:0] idx);
        entry_t e;
        e = '0;
        for (int k = 0; k < WORDS_PER_ENTRY; k++) begin
            if (k < int'(idx)) begin
                e[k*WORD_W +: WORD_W] = part[k*WORD_W +: WORD_W];
            end else if (k == int'(idx)) begin
                e[k*WORD_W +: WORD_W] = w;
            end
        end
        return e;
    endfunction

    logic [WIDX_W-1:0] word_idx_p0;
    entry_t            pack_p0;
    logic              rdy_q;
    logic              xfer;
    logic              closing;
    entry_t            close_data;

    logic              fifo_full;
    logic              fifo_empty;
    entry_t            fifo_head;
    logic              pop;

    drain_state_t      state_q;
    drain_state_t      state_nx;
    logic [GAP_W-1:0]  gap_cnt_q;

    // ---- stage p0: word acceptance and packing ----
    assign in_ready   = rdy_q & (~fifo_full | pop);
    assign xfer       = in_valid & in_ready;
    assign closing    = xfer & (in_last | (word_idx_p0 == LAST_IDX));
    assign close_data = close_entry(pack_p0, in_data, word_idx_p0);
    assign busy       = (word_idx_p0 != '0) | (fifo_level != '0);

    // in_ready stays low for the cycle after any reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Word position within the open entry; returns to 0 when the entry closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx_p0 <= '0;
        end else if (xfer) begin
            word_idx_p0 <= closing ? '0 : word_idx_p0 + 1'b1;
        end
    end

    // Partial entry buffer; only the slot of the accepted word is written.
    always_ff @(posedge clk) begin
        if (xfer) begin
            pack_p0[int'(word_idx_p0)*WORD_W +: WORD_W] <= in_data;
        end
    end

    // ---- stage p1: closed entries queued for commit ----
    boreal_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (closing),
        .push_data (close_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // ---- stage p2: drain FSM and registered commit port ----
    // Drain FSM state register and gap counter; the counter is loaded on each
    // pop so the following commit is WR_GAP+1 cycles after the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DRN_IDLE;
            gap_cnt_q <= '0;
            wr_en     <= 1'b0;
        end else begin
            state_q <= state_nx;
            wr_en   <= pop;
            if (pop) begin
                gap_cnt_q <= GAP_LOAD;
            end else if (gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    // Next-state and pop decision; the commit cycle is the one after the pop.
    always_comb begin
        pop      = 1'b0;
        state_nx = state_q;
        if (!fifo_empty && gap_cnt_q == '0) begin
            pop      = 1'b1;
            state_nx = DRN_COMMIT;
        end else begin
            case (state_q)
                DRN_COMMIT: state_nx = (WR_GAP > 0) ? DRN_GAP : DRN_IDLE;
                DRN_GAP:    state_nx = (gap_cnt_q == '0) ? DRN_IDLE : DRN_GAP;
                default:    state_nx = DRN_IDLE;
            endcase
        end
    end

    // Commit data captured from the FIFO head on pop; holds while wr_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data <= '0;
        end else if (pop) begin
            wr_data <= fifo_head;
        end
    end

`ifdef BOREAL_FEEDER_CNT_EN
    logic [31:0] entry_cnt_q;
    logic [31:0] pad_cnt_q;

    assign entry_cnt = entry_cnt_q;
    assign pad_cnt   = pad_cnt_q;

    // Statistics: commits counted with their wr_en, early closes at closing time.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_cnt_q <= '0;
            pad_cnt_q   <= '0;
        end else begin
            if (pop) begin
                entry_cnt_q <= entry_cnt_q + 1'b1;
            end
            if (closing && in_last && word_idx_p0 != LAST_IDX) begin
                pad_cnt_q <= pad_cnt_q + 1'b1;
            end
        end
    end
`endif

endmodule
